rocketcpu_sample_fifo: RTL and testbench

ROCKETCPU_SAMPLE_FIFO -- requirements
Module: rocketcpu_sample_fifo

---
 rtl/rocketcpu_sample_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_rocketcpu_sample_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_sample_fifo.sv
// Wishbone-fed stereo sample FIFO: the CPU pushes 32-bit words, the audio
// pipeline pops one per sample request, with a low-water interrupt.
module rocketcpu_sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 5
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_sample_req,
  output logic [31:0] o_sample,
  output logic        o_sample_valid,
  output logic        o_irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 8;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_THRESH = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [LW-1:0] THRESH_RST = LW'(4);
  localparam logic [LW-1:0] LEVEL_MAX  = LW'(DEPTH);
  localparam logic [CW-1:0] UCNT_MAX   = '1;

  // Storage and architectural state
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [LW-1:0] level;
  logic [LW-1:0] thresh;
  logic          enable;
  logic          unf_sticky;
  logic          ovf_sticky;
  logic [CW-1:0] ucnt;

  // Decoded bus and FIFO events
  logic          bus_acc;
  logic          bus_wr;
  logic          bus_req;
  logic [1:0]    reg_sel;
  logic          data_wr;
  logic          status_wr;
  logic          thresh_wr;
  logic          ctrl_wr;
  logic          clr;
  logic          empty;
  logic          full;
  logic [DW-1:0] head;
  logic          pop;
  logic          under;
  logic          push;
  logic          drop;

  // Next-state values
  logic [PW-1:0] rptr_n;
  logic [PW-1:0] wptr_n;
  logic [LW-1:0] level_n;
  logic [LW-1:0] thresh_n;
  logic          enable_n;
  logic          unf_n;
  logic          ovf_n;
  logic [CW-1:0] ucnt_n;
  logic          irq_n;

  logic [DW-1:0] status_word;
  logic [DW-1:0] rdt_n;

  logic unused_bits;
  assign unused_bits = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_sel[3:1]};

  // Side effects take place only during the acknowledged cycle
  always_comb begin
    bus_acc   = o_wb_ack & i_wb_cyc;
    bus_wr    = bus_acc & i_wb_we;
    bus_req   = i_wb_cyc & ~o_wb_ack;
    reg_sel   = i_wb_adr[3:2];
    data_wr   = bus_wr & (reg_sel == REG_DATA);
    status_wr = bus_wr & (reg_sel == REG_STATUS);
    thresh_wr = bus_wr & (reg_sel == REG_THRESH) & i_wb_sel[0];
    ctrl_wr   = bus_wr & (reg_sel == REG_CTRL);
    clr       = ctrl_wr & i_wb_dat[1];

    empty = (level == '0);
    full  = (level == LEVEL_MAX);
    head  = empty ? '0 : mem[rptr];

    // Clear beats a pop; a push can still use the slot freed by a pop
    pop   = i_sample_req & enable & ~empty & ~clr;
    under = i_sample_req & enable & empty & ~clr;
    push  = data_wr & (~full | pop);
    drop  = data_wr & ~push;
  end

  always_comb begin
    rptr_n   = rptr;
    wptr_n   = wptr;
    level_n  = level;
    thresh_n = thresh;
    enable_n = enable;
    unf_n    = unf_sticky;
    ovf_n    = ovf_sticky;
    ucnt_n   = ucnt;

    if (thresh_wr) begin
      thresh_n = i_wb_dat[LW-1:0];
    end
    if (ctrl_wr && i_wb_sel[0]) begin
      enable_n = i_wb_dat[0];
    end

    if (clr) begin
      rptr_n  = '0;
      wptr_n  = '0;
      level_n = '0;
      unf_n   = 1'b0;
      ovf_n   = 1'b0;
      ucnt_n  = '0;
    end else begin
      if (pop) begin
        rptr_n = rptr + PW'(1);
      end
      if (push) begin
        wptr_n = wptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_n = level + LW'(1);
        2'b01:   level_n = level - LW'(1);
        default: level_n = level;
      endcase

      // New events win over a write-1-to-clear in the same cycle
      if (under) begin
        unf_n = 1'b1;
      end else if (status_wr && i_wb_dat[10]) begin
        unf_n = 1'b0;
      end
      if (drop) begin
        ovf_n = 1'b1;
      end else if (status_wr && i_wb_dat[11]) begin
        ovf_n = 1'b0;
      end
      if (under && (ucnt != UCNT_MAX)) begin
        ucnt_n = ucnt + CW'(1);
      end
    end

    irq_n = enable_n & (level_n <= thresh_n);
  end

  // Read data is captured on the request edge so it is valid with ack
  always_comb begin
    status_word         = '0;
    status_word[LW-1:0] = level;
    status_word[8]      = empty;
    status_word[9]      = full;
    status_word[10]     = unf_sticky;
    status_word[11]     = ovf_sticky;
    status_word[23:16]  = ucnt;

    rdt_n = '0;
    if (bus_req) begin
      case (reg_sel)
        REG_DATA:   rdt_n = head;
        REG_STATUS: rdt_n = status_word;
        REG_THRESH: rdt_n = DW'(thresh);
        REG_CTRL:   rdt_n = DW'(enable);
        default:    rdt_n = '0;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (!reset && push) begin
      mem[wptr] <= i_wb_dat;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      o_wb_ack       <= 1'b0;
      o_wb_rdt       <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_irq          <= 1'b0;
      rptr           <= '0;
      wptr           <= '0;
      level          <= '0;
      thresh         <= THRESH_RST;
      enable         <= 1'b0;
      unf_sticky     <= 1'b0;
      ovf_sticky     <= 1'b0;
      ucnt           <= '0;
    end else begin
      o_wb_ack   <= bus_req;
      o_wb_rdt   <= rdt_n;
      o_irq      <= irq_n;
      rptr       <= rptr_n;
      wptr       <= wptr_n;
      level      <= level_n;
      thresh     <= thresh_n;
      enable     <= enable_n;
      unf_sticky <= unf_n;
      ovf_sticky <= ovf_n;
      ucnt       <= ucnt_n;

      // Underflow and clear keep the last sample; disabled outputs silence
      o_sample_valid <= i_sample_req;
      if (i_sample_req) begin
        if (!enable) begin
          o_sample <= '0;
        end else if (pop) begin
          o_sample <= head;
        end
      end
    end
  end

endmodule

// File: tb/tb_rocketcpu_sample_fifo.sv
// Directed bench for rocketcpu_sample_fifo with a queue-based scoreboard
// holding the words the DUT is expected to emit.
module tb_rocketcpu_sample_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  logic        sample_req;
  logic [31:0] sample;
  logic        sample_valid;
  logic        irq;

  always #5 clk = ~clk;

  rocketcpu_sample_fifo #(.DEPTH(16), .LW(5)) dut (
    .i_wb_clk      (clk),
    .reset         (reset),
    .i_wb_adr      (adr),
    .i_wb_dat      (dat),
    .i_wb_sel      (sel),
    .i_wb_we       (we),
    .i_wb_cyc      (cyc),
    .o_wb_rdt      (rdt),
    .o_wb_ack      (ack),
    .i_sample_req  (sample_req),
    .o_sample      (sample),
    .o_sample_valid(sample_valid),
    .o_irq         (irq)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model
  logic [31:0] q[$];
  bit          m_en;
  logic [4:0]  m_th;
  bit          m_unf;
  bit          m_ovf;
  int          m_ucnt;
  logic [31:0] m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(q.size());
    s[8] = (q.size() == 0);
    s[9] = (q.size() == 16);
    s[10] = m_unf;
    s[11] = m_ovf;
    s[23:16] = 8'(m_ucnt);
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_en && (q.size() <= int'(m_th));
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 0; m_th = 5'd4; m_unf = 0; m_ovf = 0; m_ucnt = 0; m_last = '0;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a)
      2'd0: if (q.size() < 16) q.push_back(d); else m_ovf = 1;
      2'd1: begin if (d[10]) m_unf = 0; if (d[11]) m_ovf = 0; end
      2'd2: if (s[0]) m_th = d[4:0];
      default: begin
        if (s[0]) m_en = d[0];
        if (d[1]) begin q.delete(); m_unf = 0; m_ovf = 0; m_ucnt = 0; end
      end
    endcase
  endtask

  function automatic logic [31:0] model_sample();
    logic [31:0] e;
    if (!m_en) e = '0;
    else if (q.size() > 0) e = q.pop_front();
    else begin
      e = m_last;
      m_unf = 1;
      if (m_ucnt < 255) m_ucnt++;
    end
    m_last = e;
    return e;
  endfunction

  // One Wishbone access; optionally raises sample_req in the ack cycle
  task automatic wb(input logic [1:0] a, input logic [31:0] d, input logic w,
                    input logic [3:0] s, input bit with_req, output logic [31:0] rd);
    logic [31:0] e;
    adr = {28'd0, a, 2'b00}; dat = d; we = w; sel = s; cyc = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4 && !ack; i++) begin @(posedge clk); #1; end
    check("ack", 32'(ack), 32'd1);
    rd = rdt;
    if (with_req) sample_req = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0; sample_req = 1'b0;
    check("ack_drop", 32'(ack), 32'd0);
    if (with_req) begin
      e = model_sample();
      check("req_valid", 32'(sample_valid), 32'd1);
      check("req_sample", sample, e);
    end
    if (w) model_write(a, d, s);
    check("irq", 32'(irq), 32'(exp_irq()));
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb(a, d, 1'b1, 4'hF, 1'b0, rd);
  endtask

  task automatic reg_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb(a, 32'd0, 1'b0, 4'hF, 1'b0, rd);
    check(tag, rd, exp);
  endtask

  task automatic sample_pulse();
    logic [31:0] e;
    sample_req = 1'b1;
    @(posedge clk); #1;
    sample_req = 1'b0;
    e = model_sample();
    check("valid", 32'(sample_valid), 32'd1);
    check("sample", sample, e);
    check("irq", 32'(irq), 32'(exp_irq()));
    @(posedge clk); #1;
    check("valid_pulse", 32'(sample_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc = 1'b0; we = 1'b0; sample_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_sample", sample, 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; sample_req = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    reg_read("status_rst", 2'd1, 32'h0000_0100);
    reg_read("thresh_rst", 2'd2, 32'd4);
    reg_read("data_empty", 2'd0, 32'd0);

    // Basic push/pop
    reg_write(2'd3, 32'h1);
    reg_read("ctrl_rd", 2'd3, 32'h1);
    reg_write(2'd0, 32'h1111_2222);
    reg_write(2'd0, 32'h3333_4444);
    reg_read("status_2", 2'd1, exp_status());
    sample_pulse();
    sample_pulse();
    reg_read("status_drained", 2'd1, exp_status());

    // THRESH byte-select gating
    wb(2'd2, 32'h7, 1'b1, 4'hE, 1'b0, rd);
    reg_read("thresh_sel0", 2'd2, 32'd4);

    // Low-water interrupt and clear
    reg_write(2'd2, 32'h2);
    reg_write(2'd0, 32'hA000_000A);
    reg_write(2'd0, 32'hB000_000B);
    reg_write(2'd0, 32'hC000_000C);
    check("irq_lvl3", 32'(irq), 32'd0);
    sample_pulse();
    check("irq_lvl2", 32'(irq), 32'd1);
    reg_read("data_peek", 2'd0, 32'hB000_000B);
    reg_read("status_peek", 2'd1, exp_status());
    reg_write(2'd3, 32'h3);
    reg_read("status_clr", 2'd1, 32'h0000_0100);
    check("irq_clr", 32'(irq), 32'd1);

    // Overflow on the 17th push
    for (int i = 0; i < 17; i++) reg_write(2'd0, 32'h0000_1000 + 32'(i));
    reg_read("status_full", 2'd1, 32'h0000_0A10);
    reg_write(2'd1, 32'h800);
    reg_read("status_ovf_w1c", 2'd1, 32'h0000_0210);
    for (int i = 0; i < 16; i++) sample_pulse();
    sample_pulse();
    reg_read("status_unf1", 2'd1, exp_status());

    // Simultaneous push and pop when full, then push with underflow when empty
    reg_write(2'd3, 32'h3);
    for (int i = 0; i < 16; i++) reg_write(2'd0, 32'h0000_2000 + 32'(i));
    wb(2'd0, 32'h0000_2FFF, 1'b1, 4'hF, 1'b1, rd);
    reg_read("status_full_pp", 2'd1, 32'h0000_0210);
    reg_write(2'd3, 32'h3);
    wb(2'd0, 32'h0000_3ABC, 1'b1, 4'hF, 1'b1, rd);
    reg_read("status_empty_pp", 2'd1, 32'h0001_0401);
    reg_read("data_after_pp", 2'd0, 32'h0000_3ABC);

    // Underflow count saturation
    reg_write(2'd3, 32'h3);
    for (int i = 0; i < 300; i++) sample_pulse();
    reg_read("status_sat", 2'd1, 32'h00FF_0500);
    reg_write(2'd1, 32'h400);
    reg_read("status_unf_w1c", 2'd1, 32'h00FF_0100);

    // Disabled requests output silence without underflow
    reg_write(2'd3, 32'h0);
    sample_pulse();
    reg_read("status_dis", 2'd1, 32'h00FF_0100);

    // Reset during an acknowledged push drops it
    reg_write(2'd2, 32'h7);
    reg_write(2'd3, 32'h1);
    adr = 32'd0; dat = 32'hDEAD_BEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1;
    @(posedge clk); #1;
    check("mid_ack", 32'(ack), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_ack_drop", 32'(ack), 32'd0);
    check("mid_irq", 32'(irq), 32'd0);
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    reg_read("status_mid_rst", 2'd1, 32'h0000_0100);
    reg_read("thresh_mid_rst", 2'd2, 32'd4);
    reg_read("ctrl_mid_rst", 2'd3, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
